// File: rtl/inst_encoder.sv
// inst_encoder: packs opcode, funct3, register fields and a 32-bit immediate into an RV32I
// instruction word, the inverse of the immediate generator. Out-of-range immediates or
// unsupported opcodes produce NOP_WORD with Err_o set. The LI pseudo-op expands to ADDI, LUI,
// or LUI followed by ADDI.
//
// Ports
//   clk_i, rst_ni        clock (rising edge) and asynchronous active-low reset
//   Valid_i / Ready_o    request handshake; accepted when both are high at a clock edge
//   Li_i                 1 = LI pseudo-op (only Rd_i and Imm_i are used)
//   Opcode_i, Funct3_i   format select and funct3 field
//   Rd_i, Rs1_i, Rs2_i   register fields
//   Imm_i                signed immediate (byte offset for B/J, full value for U/LI)
//   Valid_o / Ready_i    output handshake; word consumed when both are high at a clock edge
//   Inst_o               encoded instruction word
//   Err_o                request was illegal and Inst_o holds NOP_WORD
//   Last_o               Inst_o is the final word of its request
module inst_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        Valid_i,
  output logic        Ready_o,
  input  logic        Li_i,
  input  logic [6:0]  Opcode_i,
  input  logic [2:0]  Funct3_i,
  input  logic [4:0]  Rd_i,
  input  logic [4:0]  Rs1_i,
  input  logic [4:0]  Rs2_i,
  input  logic [31:0] Imm_i,
  output logic        Valid_o,
  input  logic        Ready_i,
  output logic [31:0] Inst_o,
  output logic        Err_o,
  output logic        Last_o
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [1:0] {StEmpty, StOne, StHi} state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic [31:0] addi_q, addi_d;

  // Request decode.
  logic        fits12, fits13, fits21;
  logic [31:0] li_sum;
  logic [31:0] enc_word;
  logic [31:0] enc_addi;
  logic        enc_err;
  logic        enc_two;
  logic        accept;

  // A signed value fits in N bits when all bits from N-1 upward agree.
  assign fits12 = (&Imm_i[31:11]) | ~(|Imm_i[31:11]);
  assign fits13 = (&Imm_i[31:12]) | ~(|Imm_i[31:12]);
  assign fits21 = (&Imm_i[31:20]) | ~(|Imm_i[31:20]);
  // Rounding hi20 up compensates for the ADDI sign-extending lo12.
  assign li_sum = Imm_i + 32'h00000800;

  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    enc_addi = {Imm_i[11:0], Rd_i, 3'b000, Rd_i, OpOpImm};
    if (Li_i) begin
      if (fits12) begin
        enc_word = {Imm_i[11:0], 5'd0, 3'b000, Rd_i, OpOpImm};
      end else if (Imm_i[11:0] == 12'd0) begin
        enc_word = {Imm_i[31:12], Rd_i, OpLui};
      end else begin
        enc_word = {li_sum[31:12], Rd_i, OpLui};
        enc_two  = 1'b1;
      end
    end else begin
      case (Opcode_i)
        OpOpImm, OpLoad, OpJalr: begin
          enc_err  = ~fits12;
          enc_word = {Imm_i[11:0], Rs1_i, Funct3_i, Rd_i, Opcode_i};
        end
        OpStore: begin
          enc_err  = ~fits12;
          enc_word = {Imm_i[11:5], Rs2_i, Rs1_i, Funct3_i, Imm_i[4:0], Opcode_i};
        end
        OpBranch: begin
          enc_err  = ~fits13 | Imm_i[0];
          enc_word = {Imm_i[12], Imm_i[10:5], Rs2_i, Rs1_i, Funct3_i, Imm_i[4:1], Imm_i[11],
                      Opcode_i};
        end
        OpJal: begin
          enc_err  = ~fits21 | Imm_i[0];
          enc_word = {Imm_i[20], Imm_i[10:1], Imm_i[11], Imm_i[19:12], Rd_i, Opcode_i};
        end
        OpLui: begin
          enc_err  = |Imm_i[11:0];
          enc_word = {Imm_i[31:12], Rd_i, Opcode_i};
        end
        default: enc_err = 1'b1;
      endcase
      if (enc_err) begin
        enc_word = NOP_WORD;
      end
    end
  end

  // Output handshake / FSM.
  always_comb begin
    Ready_o = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        StEmpty: Ready_o = 1'b1;
        StOne:   Ready_o = Ready_i;
        StHi:    Ready_o = 1'b0;
        default: Ready_o = 1'b0;
      endcase
    end
  end

  assign accept = Valid_i & Ready_o;

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    err_d   = err_q;
    addi_d  = addi_q;
    unique case (state_q)
      StEmpty, StOne: begin
        if (accept) begin
          inst_d  = enc_word;
          err_d   = enc_err;
          addi_d  = enc_addi;
          state_d = enc_two ? StHi : StOne;
        end else if (state_q == StOne && Ready_i) begin
          state_d = StEmpty;
        end
      end
      StHi: begin
        if (Ready_i) begin
          inst_d  = addi_q;
          err_d   = 1'b0;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      inst_q  <= 32'd0;
      err_q   <= 1'b0;
      addi_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      addi_q  <= addi_d;
    end
  end

  assign Valid_o = (state_q != StEmpty);
  assign Last_o  = (state_q == StOne);
  assign Inst_o  = inst_q;
  assign Err_o   = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        Valid_i, Ready_o, Li_i, Valid_o, Ready_i, Err_o, Last_o;
  logic [6:0]  Opcode_i;
  logic [2:0]  Funct3_i;
  logic [4:0]  Rd_i, Rs1_i, Rs2_i;
  logic [31:0] Imm_i, Inst_o;

  always #5 clk_i = ~clk_i;

  inst_encoder dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .Valid_i  (Valid_i),
    .Ready_o  (Ready_o),
    .Li_i     (Li_i),
    .Opcode_i (Opcode_i),
    .Funct3_i (Funct3_i),
    .Rd_i     (Rd_i),
    .Rs1_i    (Rs1_i),
    .Rs2_i    (Rs2_i),
    .Imm_i    (Imm_i),
    .Valid_o  (Valid_o),
    .Ready_i  (Ready_i),
    .Inst_o   (Inst_o),
    .Err_o    (Err_o),
    .Last_o   (Last_o)
  );

  typedef struct {
    logic        li;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int bnd [16] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098,
                   -1048576, 1048574, 1048576, 32'h7FFFF800, 32'h80000000, 32'hFFFFF000,
                   32'h00000800, 32'h12345678};
  logic [6:0] ops [8] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h33};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk(logic li, logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
    req_t r;
    r.li = li; r.op = op; r.f3 = f3; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  // Reference encoders built from field arithmetic on the immediate value.
  function automatic logic [31:0] regs(logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
                                       logic [4:0] rs1, logic [4:0] rs2);
    return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
  endfunction

  function automatic logic [31:0] bits(logic [31:0] v, int lsb, logic [31:0] mask, int pos);
    return ((v >> lsb) & mask) << pos;
  endfunction

  function automatic void push(logic [31:0] inst, logic err, logic last);
    word_t w;
    w.inst = inst; w.err = err; w.last = last;
    exp_q.push_back(w);
  endfunction

  function automatic void model_push(req_t r);
    int s;
    int lo;
    logic [31:0] hi;
    logic [31:0] w;
    logic ok;
    s = int'(r.imm);
    if (r.li) begin
      if (s >= -2048 && s <= 2047) begin
        push(bits(r.imm, 0, 32'hFFF, 20) | regs(7'h13, 3'd0, r.rd, 5'd0, 5'd0), 1'b0, 1'b1);
      end else if (r.imm % 4096 == 0) begin
        push((r.imm & 32'hFFFFF000) | regs(7'h37, 3'd0, r.rd, 5'd0, 5'd0), 1'b0, 1'b1);
      end else begin
        lo = int'(r.imm & 32'hFFF);
        if (lo >= 2048) lo = lo - 4096;
        hi = r.imm - 32'(lo);
        push((hi & 32'hFFFFF000) | regs(7'h37, 3'd0, r.rd, 5'd0, 5'd0), 1'b0, 1'b0);
        push(bits(r.imm, 0, 32'hFFF, 20) | regs(7'h13, 3'd0, r.rd, r.rd, 5'd0), 1'b0, 1'b1);
      end
      return;
    end
    ok = 1'b1;
    w  = 32'h13;
    case (r.op)
      7'h13, 7'h03, 7'h67: begin
        ok = (s >= -2048 && s <= 2047);
        w  = bits(r.imm, 0, 32'hFFF, 20) | regs(r.op, r.f3, r.rd, r.rs1, 5'd0);
      end
      7'h23: begin
        ok = (s >= -2048 && s <= 2047);
        w  = bits(r.imm, 5, 32'h7F, 25) | bits(r.imm, 0, 32'h1F, 7) |
             regs(r.op, r.f3, 5'd0, r.rs1, r.rs2);
      end
      7'h63: begin
        ok = (s >= -4096 && s <= 4094 && r.imm % 2 == 0);
        w  = bits(r.imm, 12, 1, 31) | bits(r.imm, 5, 32'h3F, 25) | bits(r.imm, 1, 32'hF, 8) |
             bits(r.imm, 11, 1, 7) | regs(r.op, r.f3, 5'd0, r.rs1, r.rs2);
      end
      7'h6F: begin
        ok = (s >= -1048576 && s <= 1048574 && r.imm % 2 == 0);
        w  = bits(r.imm, 20, 1, 31) | bits(r.imm, 1, 32'h3FF, 21) | bits(r.imm, 11, 1, 20) |
             bits(r.imm, 12, 32'hFF, 12) | regs(r.op, 3'd0, r.rd, 5'd0, 5'd0);
      end
      7'h37: begin
        ok = (r.imm % 4096 == 0);
        w  = (r.imm & 32'hFFFFF000) | regs(r.op, 3'd0, r.rd, 5'd0, 5'd0);
      end
      default: ok = 1'b0;
    endcase
    if (ok) push(w, 1'b0, 1'b1);
    else    push(32'h00000013, 1'b1, 1'b1);
  endfunction

  // One cycle: drive at the falling edge, check outputs 1 ns later against the scoreboard.
  task automatic step(input req_t r, input logic v, input logic rdy, output logic acc);
    logic [31:0] exp_ready;
    @(negedge clk_i);
    Valid_i = v; Ready_i = rdy; Li_i = r.li; Opcode_i = r.op; Funct3_i = r.f3;
    Rd_i = r.rd; Rs1_i = r.rs1; Rs2_i = r.rs2; Imm_i = r.imm;
    #1;
    check("valid", 32'(Valid_o), 32'(exp_q.size() != 0));
    exp_ready = (exp_q.size() == 0) ? 32'd1 : (exp_q.size() == 1) ? 32'(rdy) : 32'd0;
    check("ready", 32'(Ready_o), exp_ready);
    if (exp_q.size() != 0) begin
      check("inst", Inst_o, exp_q[0].inst);
      check("err", 32'(Err_o), 32'(exp_q[0].err));
      check("last", 32'(Last_o), 32'(exp_q[0].last));
    end
    acc = v & Ready_o;
    if (Valid_o && rdy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) model_push(r);
  endtask

  task automatic send(input req_t r);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(r, 1'b1, 1'b1, acc);
    check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input logic rdy);
    logic acc;
    step(mk(1'b0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0), 1'b0, rdy, acc);
  endtask

  initial begin
    req_t r;
    logic acc;
    rst_ni = 1'b0; Valid_i = 1'b0; Ready_i = 1'b0; Li_i = 1'b0; Opcode_i = 7'd0;
    Funct3_i = 3'd0; Rd_i = 5'd0; Rs1_i = 5'd0; Rs2_i = 5'd0; Imm_i = 32'd0;
    #3;
    check("rst_valid", 32'(Valid_o), 32'd0);
    check("rst_inst", Inst_o, 32'd0);
    check("rst_err", 32'(Err_o), 32'd0);
    check("rst_last", 32'(Last_o), 32'd0);
    check("rst_ready", 32'(Ready_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    send(mk(1'b0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFFFFFF));
    idle(1'b1);
    check("I_inst", Inst_o, 32'hFFF30293);
    check("I_err", 32'(Err_o), 32'd0);
    check("I_last", 32'(Last_o), 32'd1);

    send(mk(1'b0, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC));
    idle(1'b1);
    check("B_inst", Inst_o, 32'hFE208EE3);
    send(mk(1'b0, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3));
    idle(1'b1);
    check("Bodd_inst", Inst_o, 32'h00000013);
    check("Bodd_err", 32'(Err_o), 32'd1);

    send(mk(1'b1, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345678));
    idle(1'b1);
    check("LI_lui", Inst_o, 32'h12345537);
    check("LI_lui_last", 32'(Last_o), 32'd0);
    idle(1'b1);
    check("LI_addi", Inst_o, 32'h67850513);
    check("LI_addi_last", 32'(Last_o), 32'd1);

    send(mk(1'b1, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h7FFFF800));
    idle(1'b1);
    check("LIwrap_lui", Inst_o, 32'h800000B7);
    idle(1'b1);
    check("LIwrap_addi", Inst_o, 32'h80008093);

    // Backpressure on a two-word LI.
    send(mk(1'b1, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345678));
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check("bp_lui", Inst_o, 32'h12345537);
      check("bp_ready", 32'(Ready_o), 32'd0);
    end
    idle(1'b1);
    idle(1'b1);

    // Reset while the ADDI is pending.
    send(mk(1'b1, 7'h00, 3'd0, 5'd3, 5'd0, 5'd0, 32'h12345678));
    idle(1'b0);
    rst_ni = 1'b0;
    #1;
    check("rstHI_valid", 32'(Valid_o), 32'd0);
    check("rstHI_ready", 32'(Ready_o), 32'd0);
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("rstHI_noaddi", 32'(Valid_o), 32'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r.li  = ($urandom_range(0, 3) == 0);
      r.op  = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      r.f3  = 3'($urandom);
      r.rd  = 5'($urandom);
      r.rs1 = 5'($urandom);
      r.rs2 = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       r.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
        1:       r.imm = 32'(bnd[$urandom_range(0, 15)]);
        2:       r.imm = $urandom;
        default: r.imm = $urandom & 32'hFFFFF000;
      endcase
      step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), acc);
    end
    for (int i = 0; i < 10; i++) idle(1'b1);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
